// File: rtl/vram_arbiter_pkg.sv
// Shared video definitions: display geometry, tile-map widths and the
// tile-map address helper used by the timing generator, renderer and arbiter.
package vram_arbiter_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int TILE_COLS = 40;
  localparam int TILE_ROWS = 30;
  localparam int TILE_AW   = 11;
  localparam int TILE_CW   = 8;

  typedef logic [TILE_AW-1:0] tile_addr_t;
  typedef logic [TILE_CW-1:0] tile_code_t;

  typedef enum logic {
    WR0 = 1'b0,
    WR1 = 1'b1
  } writer_e;

  // Multiply by a constant column count folds to a shift-add in synthesis.
  function automatic tile_addr_t tile_map_addr(input logic [5:0] row,
                                               input logic [5:0] col,
                                               input int         cols);
    return tile_addr_t'(row) * tile_addr_t'(cols) + tile_addr_t'(col);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Tile-map bus: raster counters, two writer ports, RAM port and tile output.
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       req0;
  logic       req1;
  tile_addr_t addr0;
  tile_addr_t addr1;
  tile_code_t data0;
  tile_code_t data1;
  logic       gnt0;
  logic       gnt1;
  tile_addr_t ram_addr;
  tile_code_t ram_wdata;
  logic       ram_we;
  tile_code_t ram_rdata;
  tile_code_t tile_idx;
  logic       tile_valid;

  modport master (
    input  hcnt, vcnt, req0, req1, addr0, addr1, data0, data1, ram_rdata,
    output gnt0, gnt1, ram_addr, ram_wdata, ram_we, tile_idx, tile_valid
  );

  modport slave (
    output hcnt, vcnt, req0, req1, addr0, addr1, data0, data1, ram_rdata,
    input  gnt0, gnt1, ram_addr, ram_wdata, ram_we, tile_idx, tile_valid
  );

endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin picker with eligibility masks and a registered
// preference pointer; the pick is combinational, the caller registers it.
module vram_arbiter_rr_arb2
  import vram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  writer_e    pref_q;
  writer_e    pref_d;
  logic [1:0] elig;

  always_comb begin
    elig   = req & ~mask;
    gnt    = 2'b00;
    pref_d = pref_q;
    if (en && (elig != 2'b00)) begin
      if (elig == 2'b11) begin
        gnt = (pref_q == WR0) ? 2'b01 : 2'b10;
      end else begin
        gnt = elig;
      end
      // Next preference is the writer that just lost (or was not served).
      pref_d = gnt[0] ? WR1 : WR0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pref_q <= WR0;
    end else begin
      pref_q <= pref_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Tile-map RAM arbiter: display tile fetches on 16-pixel slots take absolute
// priority, remaining cycles are shared round-robin between two writers.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int H_ACTIVE  = vram_arbiter_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vram_arbiter_pkg::V_ACTIVE,
  parameter int TILE_COLS = vram_arbiter_pkg::TILE_COLS,
  parameter int TILE_ROWS = vram_arbiter_pkg::TILE_ROWS
) (
  input logic             clk,
  input logic             reset,
  vram_arbiter_if.master  bus
);

  localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
  localparam logic [5:0] ROW_LIM = 6'(TILE_ROWS);

  logic       slot;
  logic [5:0] row;
  logic [5:0] col;
  logic [1:0] arb_gnt;

  tile_addr_t ram_addr_q,   ram_addr_d;
  tile_code_t ram_wdata_q,  ram_wdata_d;
  logic       ram_we_q,     ram_we_d;
  logic       gnt0_q,       gnt0_d;
  logic       gnt1_q,       gnt1_d;
  logic [1:0] rd_pipe_q,    rd_pipe_d;
  tile_code_t tile_idx_q,   tile_idx_d;
  logic       tile_valid_q, tile_valid_d;

  assign row  = bus.vcnt[9:4];
  assign col  = bus.hcnt[9:4];
  assign slot = (bus.hcnt < H_LIM) && (bus.vcnt < V_LIM) &&
                (bus.hcnt[3:0] == 4'd0) && (row < ROW_LIM);

  vram_arbiter_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (~slot),
    .req   ({bus.req1, bus.req0}),
    .mask  ({gnt1_q, gnt0_q}),
    .gnt   (arb_gnt)
  );

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    gnt0_d      = arb_gnt[0];
    gnt1_d      = arb_gnt[1];
    if (slot) begin
      ram_addr_d = tile_map_addr(row, col, TILE_COLS);
    end else if (arb_gnt[0]) begin
      ram_addr_d  = bus.addr0;
      ram_wdata_d = bus.data0;
      ram_we_d    = 1'b1;
    end else if (arb_gnt[1]) begin
      ram_addr_d  = bus.addr1;
      ram_wdata_d = bus.data1;
      ram_we_d    = 1'b1;
    end
    // Stage 0: address on the RAM; stage 1: read data valid on ram_rdata.
    rd_pipe_d    = {rd_pipe_q[0], slot};
    tile_valid_d = rd_pipe_q[1];
    tile_idx_d   = rd_pipe_q[1] ? bus.ram_rdata : tile_idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rd_pipe_q    <= 2'b00;
      tile_idx_q   <= '0;
      tile_valid_q <= 1'b0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rd_pipe_q    <= rd_pipe_d;
      tile_idx_q   <= tile_idx_d;
      tile_valid_q <= tile_valid_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.tile_idx   = tile_idx_q;
  assign bus.tile_valid = tile_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous tile RAM, queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Tile RAM with synchronous read, read-before-write.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
  end

  // Reference model: expected outputs for the cycle after each edge.
  logic [7:0]  mmem [0:2047];
  logic        e_g0 = 0, e_g1 = 0, e_we = 0, e_tv = 0;
  logic [10:0] e_addr = 0;
  logic [7:0]  e_wdata = 0, e_tile = 0;
  logic        el0, el1;
  int          pref = 0, cyc = 0, pick;
  bit          live = 0;
  int          due_q[$];
  logic [7:0]  val_q[$];

  always @(posedge clk) begin
    cyc++;
    if (e_we) mmem[e_addr] = e_wdata;
    if (reset) begin
      e_g0 = 0; e_g1 = 0; e_we = 0; e_tv = 0;
      e_addr = 0; e_wdata = 0; e_tile = 0;
      pref = 0;
      due_q.delete(); val_q.delete();
      live = 1;
    end else begin
      el0 = bus.req0 && !e_g0;
      el1 = bus.req1 && !e_g1;
      e_g0 = 0; e_g1 = 0; e_we = 0; e_tv = 0;
      if (bus.hcnt < 640 && bus.vcnt < 480 && (bus.hcnt % 16) == 0) begin
        e_addr = 11'((bus.vcnt / 16) * 40 + bus.hcnt / 16);
        due_q.push_back(cyc + 2);
        val_q.push_back(mmem[e_addr]);
      end else begin
        pick = -1;
        if (el0 && el1) pick = pref;
        else if (el0)   pick = 0;
        else if (el1)   pick = 1;
        if (pick == 0) begin
          e_g0 = 1; e_we = 1; e_addr = bus.addr0; e_wdata = bus.data0; pref = 1;
        end else if (pick == 1) begin
          e_g1 = 1; e_we = 1; e_addr = bus.addr1; e_wdata = bus.data1; pref = 0;
        end
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e_tv = 1;
        e_tile = val_q[0];
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("gnt0",       int'(bus.gnt0),       int'(e_g0));
      chk("gnt1",       int'(bus.gnt1),       int'(e_g1));
      chk("ram_we",     int'(bus.ram_we),     int'(e_we));
      chk("ram_addr",   int'(bus.ram_addr),   int'(e_addr));
      chk("tile_valid", int'(bus.tile_valid), int'(e_tv));
      chk("tile_idx",   int'(bus.tile_idx),   int'(e_tile));
      if (e_we) chk("ram_wdata", int'(bus.ram_wdata), int'(e_wdata));
      chk("gnt_excl",   int'(bus.gnt0 & bus.gnt1), 0);
      chk("we_iff_gnt", int'(bus.ram_we), int'(bus.gnt0 | bus.gnt1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int h, input int v, input bit r0, input bit r1);
    bus.hcnt = 10'(h);
    bus.vcnt = 10'(v);
    bus.req0 = r0;
    bus.req1 = r1;
  endtask

  initial begin
    int h;
    int v;
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = init_val(i);
      mmem[i] = init_val(i);
    end
    mem[122]  = 8'h5A;
    mmem[122] = 8'h5A;
    bus.addr0 = '0; bus.data0 = '0;
    bus.addr1 = '0; bus.data1 = '0;
    drive(700, 0, 0, 0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Display fetch at (32,48): address 122, tile 0x5A three cycles later.
    drive(32, 48, 0, 0);
    tick(); drive(33, 48, 0, 0);
    @(negedge clk);
    chk("r027_addr", int'(bus.ram_addr), 122);
    chk("r027_we",   int'(bus.ram_we), 0);
    tick(); drive(34, 48, 0, 0);
    tick();
    @(negedge clk);
    chk("r027_tile",  int'(bus.tile_idx), 8'h5A);
    chk("r027_valid", int'(bus.tile_valid), 1);
    tick();
    @(negedge clk);
    chk("r027_valid_off", int'(bus.tile_valid), 0);

    // Write request during a slot is deferred by one cycle.
    tick();
    bus.addr0 = 11'd7; bus.data0 = 8'h11;
    drive(16, 0, 1, 0);
    tick(); drive(17, 0, 1, 0);
    @(negedge clk);
    chk("r028_no_gnt", int'(bus.gnt0), 0);
    chk("r028_no_we",  int'(bus.ram_we), 0);
    tick(); drive(18, 0, 0, 0);
    @(negedge clk);
    chk("r028_gnt0",  int'(bus.gnt0), 1);
    chk("r028_we",    int'(bus.ram_we), 1);
    chk("r028_addr",  int'(bus.ram_addr), 7);
    chk("r028_wdata", int'(bus.ram_wdata), 8'h11);

    // Last visible slot, then first blanking column.
    tick(); drive(624, 479, 0, 0);
    tick(); drive(640, 479, 0, 0);
    @(negedge clk);
    chk("r030_addr", int'(bus.ram_addr), 1199);
    chk("r030_we",   int'(bus.ram_we), 0);
    tick(); drive(650, 479, 0, 0);
    tick();
    @(negedge clk);
    chk("r030_valid", int'(bus.tile_valid), 1);
    chk("r030_tile",  int'(bus.tile_idx), 8'h56);
    tick();
    @(negedge clk);
    chk("r030_no_read", int'(bus.tile_valid), 0);

    // Both writers hold requests in blanking: alternating grants from writer 0.
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.addr0 = 11'd100; bus.data0 = 8'h01;
    bus.addr1 = 11'd200; bus.data1 = 8'h02;
    drive(700, 500, 1, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("r029_gnt0", int'(bus.gnt0), (k % 2 == 0) ? 1 : 0);
      chk("r029_gnt1", int'(bus.gnt1), (k % 2 == 1) ? 1 : 0);
      if (k == 4) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end

    // Reset while a fetch is in flight: no tile, writer 0 preferred again.
    tick(); drive(32, 16, 0, 0);
    tick();
    reset = 1'b1;
    drive(700, 16, 1, 1);
    @(negedge clk);
    chk("r031_read_issued", int'(bus.ram_addr), 42);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("r031_gnt0",  int'(bus.gnt0), 0);
    chk("r031_gnt1",  int'(bus.gnt1), 0);
    chk("r031_we",    int'(bus.ram_we), 0);
    chk("r031_addr",  int'(bus.ram_addr), 0);
    chk("r031_wdata", int'(bus.ram_wdata), 0);
    chk("r031_tile",  int'(bus.tile_idx), 0);
    chk("r031_valid", int'(bus.tile_valid), 0);
    tick();
    @(negedge clk);
    chk("r031_first_gnt0", int'(bus.gnt0), 1);
    chk("r031_first_gnt1", int'(bus.gnt1), 0);
    chk("r031_no_tile",    int'(bus.tile_valid), 0);
    tick();
    drive(700, 16, 0, 0);
    @(negedge clk);
    chk("r031_no_tile_late", int'(bus.tile_valid), 0);

    // Sweep across the end of a line and the start of the next with both
    // writers following the hold-until-grant protocol.
    for (int k = 0; k < 280; k++) begin
      tick();
      h = 560 + k;
      v = 100;
      if (h >= 800) begin
        h = h - 800;
        v = 101;
      end
      bus.hcnt = 10'(h);
      bus.vcnt = 10'(v);
      if (bus.gnt0) begin
        bus.req0 = 1'b0;
      end else if (!bus.req0 && (k % 3) != 0) begin
        bus.req0  = 1'b1;
        bus.addr0 = 11'(300 + k);
        bus.data0 = 8'(k);
      end
      if (bus.gnt1) begin
        bus.req1 = 1'b0;
      end else if (!bus.req1 && (k % 5) != 0) begin
        bus.req1  = 1'b1;
        bus.addr1 = 11'(240 + (k % 4));
        bus.data1 = 8'(8'hC0 + k);
      end
    end

    tick();
    drive(700, 500, 0, 0);
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
